// File: rtl/pipe_reg_elastic.sv
// Elastic register chain with per-stage valid bits, bubble collapsing, one-cycle flush
// and a combinational occupancy count.
module pipe_reg_elastic #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] pred_v;
  logic [WIDTH-1:0] pred_d [DEPTH];

  // A stage can load when it is empty or anything downstream of it can move.
  always_comb begin
    logic acc;
    acc = ready_i;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      rdy[k] = acc;
    end
  end

  always_comb begin
    pred_v[0] = valid_i;
    pred_d[0] = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      pred_v[k] = v_q[k-1];
      pred_d[k] = d_q[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i) begin
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end else if (rdy[k]) begin
        // Bubbles carry zeroed data so an empty output always reads 0.
        v_d[k] = pred_v[k];
        d_d[k] = pred_v[k] ? pred_d[k] : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_o = count_o + CW'(v_q[k]);
    end
  end

  assign ready_o = rdy[0];
  assign valid_o = v_q[DEPTH-1];
  assign data_o  = d_q[DEPTH-1];

endmodule

// File: doc/pipe_reg_elastic.md
# pipe_reg_elastic

Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit data, each stage with its own valid bit and a valid/ready handshake on both ends. It succeeds the single-stage flush/stall pipeline register in the processor datapath. Global stall is replaced by per-stage backpressure with bubble collapsing, and flush clears the whole chain in one cycle. It also reports occupancy, for use between pipeline stages or in front of multi-cycle units.

## Interface
- WIDTH, 32, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1)
- CW, $clog2(DEPTH+1), width of count_o (derived, not overridden)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous clear of all stages
- valid_i  in  1  upstream item present
- ready_o  out  1  chain can accept upstream item this cycle
- data_i  in  WIDTH  upstream data
- valid_o  out  1  item present at last stage
- ready_i  in  1  downstream accepts item this cycle
- data_o  out  WIDTH  last-stage data
- count_o  out  CW  number of valid stages

## Operation
- Stages 0..DEPTH-1; stage 0 is fed by data_i/valid_i, stage DEPTH-1 drives data_o/valid_o.
- Internal ready chain: rdy[DEPTH] = ready_i; rdy[k] = ~v[k] | rdy[k+1]; ready_o = rdy[0]. The path is combinational from ready_i to ready_o; no registered skid.
- Upstream transfer: valid_i & ready_o. Downstream transfer: valid_o & ready_i.
- Each clock, when rdy[k]=1, stage k loads from its predecessor (stage k-1, or the input for k=0):
  - predecessor valid: v[k]<=1, d[k]<=predecessor data;
  - predecessor empty: v[k]<=0, d[k]<=0 (bubble advances, data zeroed).
- When rdy[k]=0, stage k holds v[k] and d[k].
- Bubble collapsing: an empty stage always accepts, so a stalled output lets upstream items pack together until all DEPTH stages are full.
- flush_i=1: next edge sets all v[k]<=0 and d[k]<=0. This overrides every load. Any upstream item offered in that cycle is dropped, even though ready_o may read 1. Any downstream transfer in that cycle still counts as completed.
- data_o = d[DEPTH-1]; valid_o = v[DEPTH-1]. data_o is 0 whenever valid_o=0 after reset or flush.
- count_o = popcount(v), combinational from stage registers, range 0..DEPTH.
- Items are never duplicated, reordered or lost except by flush or reset.

## Timing
- Reset (rst_i=0, asynchronous): all v=0, all d=0. Consequently valid_o=0, data_o=0, count_o=0, ready_o=1 (because every stage is empty). Asserting reset mid-stream discards all items immediately, without waiting for a clock edge.
- Latency: an item accepted at edge t with ready_i held at 1 appears on valid_o after edge t+DEPTH-1, i.e. DEPTH cycles from input to output register.
- Throughput: 1 item/cycle sustained when ready_i=1.
- Full: all v=1 and ready_i=0 gives ready_o=0 and count_o=DEPTH.
- Full chain with ready_i=1: ready_o=1 in the same cycle, so simultaneous push and pop keeps count_o at DEPTH.
- Empty chain: valid_o=0. ready_i is a don't-care.
- DEPTH=1: single register; ready_o = ~v[0] | ready_i.
- flush_i and rst_i together: reset wins. The result is identical anyway.

## Test plan
- Reset: drive rst_i=0 mid-stream with DEPTH=3 holding 2 items -> without a clock edge, valid_o=0, data_o=0, count_o=0, ready_o=1.
- Fill under backpressure: DEPTH=3, WIDTH=8, ready_i=0, push 0x11,0x22,0x33,0x44 on consecutive cycles -> first three accepted, ready_o=0 on the 4th, count_o=3, data_o=0x11.
- Drain and order: from the full state, set ready_i=1 and valid_i=0 -> data_o shows 0x11,0x22,0x33 on successive cycles, then valid_o=0, data_o=0, count_o=0.
- Streaming: ready_i=1, push 0x01..0x08 back-to-back -> valid_o first rises 3 cycles after the first accept, then 8 consecutive outputs 0x01..0x08 with no gaps.
- Bubble collapse: DEPTH=4, push A, idle, B with ready_i=0, then ready_i=1 -> count_o reaches 2 and A,B exit on consecutive cycles.
- Flush: DEPTH=3 full, with flush_i=1 and valid_i=1 (0x55) in the same cycle -> after the edge count_o=0, valid_o=0, and 0x55 never appears at the output.
